ddr3_init_seq: RTL and testbench

Power-up initialization sequencer for the DDR3 memory system. After a start pulse it walks the JEDEC reset/CKE/MRS/ZQ sequence and drives the DRAM command pins directly. It programs MR2, MR3, MR1 and MR0 from values supplied by the controller, which are packed from the package mode-register structs. On completion it asserts `init_done` and hands the command bus to the main controller FSM, which is held in INIT until then.

---
 rtl/ddr3_mem_pkg.sv | 82 ++++++++
 rtl/ddr3_init_seq.sv | 209 ++++++++++++++++++++
 tb/tb_ddr3_init_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ddr3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_mem_pkg
// Purpose  : Shared DDR3 definitions: power-up sequencer states, command-pin
//            encodings {cs_n,ras_n,cas_n,we_n}, mode-register structs and
//            helpers that pack them onto the A[15:0] bus.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_mem_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST_HOLD = 4'd1,
    S_CKE_WAIT = 4'd2,
    S_XPR      = 4'd3,
    S_MRS2     = 4'd4,
    S_MRS3     = 4'd5,
    S_MRS1     = 4'd6,
    S_MRS0     = 4'd7,
    S_ZQCL     = 4'd8,
    S_DONE     = 4'd9
  } init_states;

  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_DES  = 4'b1111;

  typedef struct packed {
    logic       ppd;      // A12 precharge power-down
    logic [2:0] wr;       // A11:9 write recovery
    logic       dll_rst;  // A8
    logic [3:0] cl;       // CAS latency, split over A6:4 and A2
    logic       rbt;      // A3 read burst type
    logic [1:0] bl;       // A1:0 burst length
  } mr0_t;

  typedef struct packed {
    logic       qoff;     // A12
    logic       tdqs;     // A11
    logic [2:0] rtt;      // Rtt_Nom, split over A9, A6, A2
    logic       wlvl;     // A7 write levelling
    logic [1:0] al;       // A4:3 additive latency
    logic [1:0] ods;      // drive strength, split over A5, A1
    logic       dll_dis;  // A0
  } mr1_t;

  typedef struct packed {
    logic [1:0] rtt_wr;   // A10:9
    logic       srt;      // A7
    logic       asr;      // A6
    logic [2:0] cwl;      // A5:3
  } mr2_t;

  typedef struct packed {
    logic       mpr;      // A2
    logic [1:0] mpr_loc;  // A1:0
  } mr3_t;

  function automatic logic [15:0] pack_mr0(mr0_t m);
    return {3'b000, m.ppd, m.wr, m.dll_rst, 1'b0, m.cl[3:1], m.rbt, m.cl[0], m.bl};
  endfunction

  function automatic logic [15:0] pack_mr1(mr1_t m);
    return {3'b000, m.qoff, m.tdqs, 1'b0, m.rtt[2], 1'b0, m.wlvl, m.rtt[1],
            m.ods[1], m.al, m.rtt[0], m.ods[0], m.dll_dis};
  endfunction

  function automatic logic [15:0] pack_mr2(mr2_t m);
    return {5'b00000, m.rtt_wr, 1'b0, m.srt, m.asr, m.cwl, 3'b000};
  endfunction

  function automatic logic [15:0] pack_mr3(mr3_t m);
    return {13'd0, m.mpr, m.mpr_loc};
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_init_seq
// Purpose  : DDR3 power-up sequencer. On start it walks RESET# hold, CKE
//            wait, tXPR, MRS2/3/1/0 and ZQCL, then raises a sticky init_done.
// Ports    : clk, rst_n (async, active-low), start, mr0..mr3 (MRS payloads)
//            -> ddr_rst_n, cke, cs_n/ras_n/cas_n/we_n, ba, addr, busy,
//               init_done. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_init_seq
  import ddr3_mem_pkg::*;
#(
  parameter int T_RESET_CYC  = 80000,
  parameter int T_CKE_CYC    = 200000,
  parameter int T_XPR_CYC    = 144,
  parameter int T_MRD_CYC    = 4,
  parameter int T_MOD_CYC    = 12,
  parameter int T_ZQINIT_CYC = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mr0,
  input  logic [15:0] mr1,
  input  logic [15:0] mr2,
  input  logic [15:0] mr3,
  output logic        ddr_rst_n,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [2:0]  ba,
  output logic [15:0] addr,
  output logic        busy,
  output logic        init_done
);

  localparam int MAX_T = max_int(max_int(max_int(T_RESET_CYC, T_CKE_CYC),
                                         max_int(T_XPR_CYC, T_MRD_CYC)),
                                 max_int(T_MOD_CYC, T_ZQINIT_CYC));
  localparam int MIN_T = -max_int(max_int(max_int(-T_RESET_CYC, -T_CKE_CYC),
                                          max_int(-T_XPR_CYC, -T_MRD_CYC)),
                                  max_int(-T_MOD_CYC, -T_ZQINIT_CYC));
  localparam int CNT_W = $clog2(MAX_T) + 1;

  if (MIN_T < 1) begin : g_bad_timing
    $error("ddr3_init_seq: every timing parameter must be at least 1 cycle");
  end

  localparam logic [CNT_W-1:0] c_ld_reset = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0] c_ld_cke   = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] c_ld_xpr   = CNT_W'(T_XPR_CYC - 1);
  localparam logic [CNT_W-1:0] c_ld_mrd   = CNT_W'(T_MRD_CYC - 1);
  localparam logic [CNT_W-1:0] c_ld_mod   = CNT_W'(T_MOD_CYC - 1);
  localparam logic [CNT_W-1:0] c_ld_zq    = CNT_W'(T_ZQINIT_CYC - 1);

  // Counter preload for a state: its duration minus one.
  function automatic logic [CNT_W-1:0] load_val(init_states s);
    case (s)
      S_RST_HOLD:                 return c_ld_reset;
      S_CKE_WAIT:                 return c_ld_cke;
      S_XPR:                      return c_ld_xpr;
      S_MRS2, S_MRS3, S_MRS1:     return c_ld_mrd;
      S_MRS0:                     return c_ld_mod;
      S_ZQCL:                     return c_ld_zq;
      default:                    return '0;
    endcase
  endfunction

  init_states       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_exit, w_first;

  logic             w_ddr_rst_n, w_cke, w_busy, w_done;
  logic [3:0]       w_cmd;
  logic [2:0]       w_ba;
  logic [15:0]      w_addr;

  logic             r_ddr_rst_n, r_cke, r_busy, r_done;
  logic [3:0]       r_cmd;
  logic [2:0]       r_ba;
  logic [15:0]      r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs are decoded from the current state and registered, so each
  // state's pin pattern appears one edge after the state is entered.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_exit       = (r_cnt == '0);
    w_first      = (r_cnt == load_val(r_state));
    w_ddr_rst_n  = 1'b0;
    w_cke        = 1'b0;
    w_cmd        = CMD_DES;
    w_ba         = 3'd0;
    w_addr       = 16'd0;
    w_busy       = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RST_HOLD;
      end
      S_RST_HOLD: begin
        w_busy = 1'b1;
        if (w_exit) w_state_next = S_CKE_WAIT;
      end
      S_CKE_WAIT: begin
        w_ddr_rst_n = 1'b1;
        w_busy      = 1'b1;
        if (w_exit) w_state_next = S_XPR;
      end
      S_XPR: begin
        w_ddr_rst_n = 1'b1;
        w_cke       = 1'b1;
        w_cmd       = CMD_NOP;
        w_busy      = 1'b1;
        if (w_exit) w_state_next = S_MRS2;
      end
      S_MRS2, S_MRS3, S_MRS1, S_MRS0: begin
        w_ddr_rst_n = 1'b1;
        w_cke       = 1'b1;
        w_cmd       = CMD_NOP;
        w_busy      = 1'b1;
        if (w_first) begin
          w_cmd = CMD_MRS;
          case (r_state)
            S_MRS2:  begin w_ba = 3'd2; w_addr = mr2; end
            S_MRS3:  begin w_ba = 3'd3; w_addr = mr3; end
            S_MRS1:  begin w_ba = 3'd1; w_addr = mr1; end
            default: begin w_ba = 3'd0; w_addr = mr0; end
          endcase
        end
        if (w_exit) begin
          case (r_state)
            S_MRS2:  w_state_next = S_MRS3;
            S_MRS3:  w_state_next = S_MRS1;
            S_MRS1:  w_state_next = S_MRS0;
            default: w_state_next = S_ZQCL;
          endcase
        end
      end
      S_ZQCL: begin
        w_ddr_rst_n = 1'b1;
        w_cke       = 1'b1;
        w_cmd       = CMD_NOP;
        w_busy      = 1'b1;
        if (w_first) begin
          w_cmd  = CMD_ZQCL;
          w_addr = 16'h0400;  // A10=1 selects long calibration
        end
        if (w_exit) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_ddr_rst_n = 1'b1;
        w_cke       = 1'b1;
        w_cmd       = CMD_NOP;
        w_done      = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next != r_state)
      w_cnt_next = load_val(w_state_next);
    else if (r_cnt != '0)
      w_cnt_next = r_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ddr_rst_n <= 1'b0;
      r_cke       <= 1'b0;
      r_cmd       <= CMD_DES;
      r_ba        <= 3'd0;
      r_addr      <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_ddr_rst_n <= w_ddr_rst_n;
      r_cke       <= w_cke;
      r_cmd       <= w_cmd;
      r_ba        <= w_ba;
      r_addr      <= w_addr;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign ddr_rst_n = r_ddr_rst_n;
  assign cke       = r_cke;
  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign ba        = r_ba;
  assign addr      = r_addr;
  assign busy      = r_busy;
  assign init_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_init_seq
// Purpose  : Self-checking bench for ddr3_init_seq. A timeline model derived
//            from the sequence durations predicts every output on every edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_init_seq;

  localparam int TR = 4, TC = 5, TX = 3, TM = 4, TMOD = 12, TZ = 8;
  // Offsets from the first busy edge
  localparam int OFF_CKE_W = TR;
  localparam int OFF_XPR   = TR + TC;
  localparam int OFF_MRS2  = OFF_XPR + TX;
  localparam int OFF_MRS3  = OFF_MRS2 + TM;
  localparam int OFF_MRS1  = OFF_MRS3 + TM;
  localparam int OFF_MRS0  = OFF_MRS1 + TM;
  localparam int OFF_ZQ    = OFF_MRS0 + TMOD;
  localparam int OFF_DONE  = OFF_ZQ + TZ;

  localparam logic [26:0] RESET_PINS = {1'b0, 1'b0, 4'hF, 3'd0, 16'd0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mr0, mr1, mr2, mr3;
  logic        ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, busy, init_done;
  logic [2:0]  ba;
  logic [15:0] addr;

  always #5 clk = ~clk;

  ddr3_init_seq #(
    .T_RESET_CYC (TR),
    .T_CKE_CYC   (TC),
    .T_XPR_CYC   (TX),
    .T_MRD_CYC   (TM),
    .T_MOD_CYC   (TMOD),
    .T_ZQINIT_CYC(TZ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mr0      (mr0),
    .mr1      (mr1),
    .mr2      (mr2),
    .mr3      (mr3),
    .ddr_rst_n(ddr_rst_n),
    .cke      (cke),
    .cs_n     (cs_n),
    .ras_n    (ras_n),
    .cas_n    (cas_n),
    .we_n     (we_n),
    .ba       (ba),
    .addr     (addr),
    .busy     (busy),
    .init_done(init_done)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   e;            // edge number within the current scenario
  int   s0;           // first busy edge
  bit   started;
  int   rst_rise, cke_rise, done_rise, zq_edge;
  int   mrs_edge [4];
  logic prev_rst, prev_cke, prev_done;

  wire [26:0] pins = {ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, busy, init_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge %0d: got %h expected %h", tag, e, got, exp);
  endtask

  function automatic logic [26:0] expect_pins(int edge_i);
    int          off;
    logic [3:0]  cmd;
    logic [2:0]  b;
    logic [15:0] a;
    if (!started || edge_i < s0) return RESET_PINS;
    off = edge_i - s0;
    cmd = (off < OFF_XPR) ? 4'hF : 4'h7;
    b   = 3'd0;
    a   = 16'd0;
    if      (off == OFF_MRS2) begin cmd = 4'h0; b = 3'd2; a = mr2; end
    else if (off == OFF_MRS3) begin cmd = 4'h0; b = 3'd3; a = mr3; end
    else if (off == OFF_MRS1) begin cmd = 4'h0; b = 3'd1; a = mr1; end
    else if (off == OFF_MRS0) begin cmd = 4'h0; b = 3'd0; a = mr0; end
    else if (off == OFF_ZQ)   begin cmd = 4'h6; a = 16'h0400; end
    return {(off >= OFF_CKE_W), (off >= OFF_XPR), cmd, b, a,
            (off < OFF_DONE), (off >= OFF_DONE)};
  endfunction

  task automatic clear_marks();
    rst_rise = -1; cke_rise = -1; done_rise = -1; zq_edge = -1;
    foreach (mrs_edge[i]) mrs_edge[i] = -1;
    prev_rst = 1'b0; prev_cke = 1'b0; prev_done = 1'b0;
  endtask

  // Drive start for the next edge, advance one edge, compare all outputs.
  task automatic step(input bit st);
    start = st;
    @(posedge clk);
    e++;
    if (st && !started) begin
      started = 1'b1;
      s0 = e + 1;
    end
    #1;
    check("pins", {5'b0, pins}, {5'b0, expect_pins(e)});
    if (ddr_rst_n && !prev_rst) rst_rise = e;
    if (cke && !prev_cke) cke_rise = e;
    if (init_done && !prev_done) done_rise = e;
    if ({cs_n, ras_n, cas_n, we_n} == 4'h0) mrs_edge[ba[1:0]] = e;
    if ({cs_n, ras_n, cas_n, we_n} == 4'h6 && addr[10]) zq_edge = e;
    prev_rst = ddr_rst_n; prev_cke = cke; prev_done = init_done;
    start = 1'b0;
  endtask

  // Pulse rst_n between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input bit restart_count);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", {5'b0, pins}, {5'b0, RESET_PINS});
    #1 rst_n = 1'b1;
    started = 1'b0;
    clear_marks();
    if (restart_count) e = 0;
  endtask

  initial begin
    int st_edge, ab_edge;
    rst_n = 1'b0; start = 1'b0;
    mr0 = 16'h0520; mr1 = 16'h0044; mr2 = 16'h0008; mr3 = 16'h0000;
    e = 0; s0 = 0; started = 1'b0;
    clear_marks();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {5'b0, pins}, {5'b0, RESET_PINS});
    async_reset(1);

    // No start: everything holds reset values
    for (int i = 0; i < 1000; i++) step(1'b0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Full sequence with known payloads, start at edge 10
    async_reset(1);
    for (int i = 1; i <= 60; i++) step(i == 10);
    check("rst_rise", rst_rise, 15);
    check("cke_rise", cke_rise, 20);
    check("mrs2_edge", mrs_edge[2], 23);
    check("mrs3_edge", mrs_edge[3], 27);
    check("mrs1_edge", mrs_edge[1], 31);
    check("mrs0_edge", mrs_edge[0], 35);
    check("zq_edge", zq_edge, 47);
    check("done_rise", done_rise, 55);

    // Terminal state ignores start
    for (int i = 0; i < 100; i++) step(1'($urandom));
    check("done_sticky", {30'd0, init_done, cke}, 32'd3);

    // Re-pulsed start during the sequence has no effect
    async_reset(1);
    for (int i = 1; i <= 60; i++) step(i == 10 || i == 18 || i == 40);
    check("repulse_done", done_rise, 55);

    // Abort mid-MRS3, restart at edge 40
    async_reset(1);
    for (int i = 1; i <= 30; i++) step(i == 10);
    async_reset(0);
    for (int i = 31; i <= 90; i++) step(i == 40);
    check("restart_done", done_rise, 85);

    // Randomized runs: payloads, start edge, stray start pulses, aborts
    for (int r = 0; r < 8; r++) begin
      mr0 = 16'($urandom); mr1 = 16'($urandom);
      mr2 = 16'($urandom); mr3 = 16'($urandom);
      async_reset(1);
      st_edge = $urandom_range(1, 20);
      ab_edge = ($urandom_range(0, 1) == 1) ? st_edge + $urandom_range(2, OFF_DONE) : -1;
      for (int i = 1; i <= 150; i++) begin
        step(i == st_edge || $urandom_range(0, 15) == 0);
        if (i == ab_edge) async_reset(0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
